// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
//
// Purpose:
//   Decode/issue stage that produces the ALU's inputs. One RV64 instruction
//   is accepted per valid/ready handshake together with its PC and register
//   file read data. The integer ALU subset (OP add/sub/xor/or/and, OP-IMM
//   addi/xori/ori/andi, LUI, AUIPC) is decoded into two 64-bit operands and
//   an ALU_CTR opcode. The result sits in a single pipeline register that the
//   downstream ALU and writeback logic consume. Any other encoding is flagged
//   illegal and never writes a register.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   flush      in   drops the held entry and blocks capture this cycle
//   in_valid   in   upstream offers an instruction
//   in_ready   out  stage can accept this cycle (independent of in_valid)
//   instr      in   32-bit instruction word
//   pc         in   64-bit instruction address
//   rs1_data   in   value of x[instr[19:15]]
//   rs2_data   in   value of x[instr[24:20]]
//   out_valid  out  held entry is valid
//   out_ready  in   downstream consumes the held entry this cycle
//   alu_a      out  ALU operand A
//   alu_b      out  ALU operand B
//   alu_ctrl   out  ALU operation
//   rd         out  destination register
//   wen        out  register write enable
//   illegal    out  instruction is outside the decoded subset
//   out_pc     out  PC of the held entry
// -----------------------------------------------------------------------------

package common;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4
    } ALU_CTR;

endpackage : common

module alu_issue (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [63:0]          pc,
    input  logic [63:0]          rs1_data,
    input  logic [63:0]          rs2_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          alu_a,
    output logic [63:0]          alu_b,
    output common::ALU_CTR       alu_ctrl,
    output logic [4:0]           rd,
    output logic                 wen,
    output logic                 illegal,
    output logic [63:0]          out_pc
);

    import common::*;

    // Major opcodes of the decoded subset
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // -------------------------------------------------------------------------
    // Instruction fields
    // -------------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_field;
    logic [63:0] imm_i;
    logic [63:0] imm_u;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rd_field = instr[11:7];
    assign imm_i    = {{52{instr[31]}}, instr[31:20]};
    assign imm_u    = {{32{instr[31]}}, instr[31:12], 12'h000};

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    // funct3 to ALU op for the logic/add group shared by OP and OP-IMM.
    logic   f3_ok;
    ALU_CTR f3_ctrl;

    always_comb begin
        f3_ok   = 1'b1;
        f3_ctrl = ADD;
        case (funct3)
            3'b000:  f3_ctrl = ADD;
            3'b100:  f3_ctrl = XOR;
            3'b110:  f3_ctrl = OR;
            3'b111:  f3_ctrl = AND;
            default: f3_ok   = 1'b0;
        endcase
    end

    logic   is_op_base;
    logic   is_op_sub;
    logic   is_op_imm;
    logic   is_lui;
    logic   is_auipc;
    logic   dec_legal;
    ALU_CTR dec_ctrl;
    logic [63:0] dec_a;
    logic [63:0] dec_b;
    logic   dec_wen;

    assign is_op_base = (opcode == OPC_OP) && (funct7 == F7_BASE) && f3_ok;
    assign is_op_sub  = (opcode == OPC_OP) && (funct7 == F7_ALT) && (funct3 == 3'b000);
    assign is_op_imm  = (opcode == OPC_OP_IMM) && f3_ok;
    assign is_lui     = (opcode == OPC_LUI);
    assign is_auipc   = (opcode == OPC_AUIPC);

    assign dec_legal  = is_op_base | is_op_sub | is_op_imm | is_lui | is_auipc;
    assign dec_wen    = dec_legal && (rd_field != 5'd0);

    // Illegal encodings fall through every branch and keep the zero/ADD
    // defaults, so no separate masking stage is needed.
    always_comb begin
        dec_ctrl = ADD;
        dec_a    = '0;
        dec_b    = '0;
        if (is_op_base) begin
            dec_ctrl = f3_ctrl;
            dec_a    = rs1_data;
            dec_b    = rs2_data;
        end else if (is_op_sub) begin
            dec_ctrl = SUB;
            dec_a    = rs1_data;
            dec_b    = rs2_data;
        end else if (is_op_imm) begin
            dec_ctrl = f3_ctrl;
            dec_a    = rs1_data;
            dec_b    = imm_i;
        end else if (is_lui) begin
            dec_ctrl = ADD;
            dec_a    = '0;
            dec_b    = imm_u;
        end else if (is_auipc) begin
            dec_ctrl = ADD;
            dec_a    = pc;
            dec_b    = imm_u;
        end
    end

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic accept;
    logic consume;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign consume  = out_valid && out_ready;

    // -------------------------------------------------------------------------
    // Pipeline register
    // -------------------------------------------------------------------------
    // Payload only moves on accept or reset; consume and flush drop out_valid
    // but leave the last payload visible.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= ADD;
            rd        <= '0;
            wen       <= 1'b0;
            illegal   <= 1'b0;
            out_pc    <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                alu_a    <= dec_a;
                alu_b    <= dec_b;
                alu_ctrl <= dec_ctrl;
                rd       <= rd_field;
                wen      <= dec_wen;
                illegal  <= !dec_legal;
                out_pc   <= pc;
            end
        end
    end

endmodule : alu_issue

// File: tb/tb_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue
//
// Self-checking bench for alu_issue. A behavioural model of the stage (an
// instruction-to-result function plus a one-entry valid/payload state) is
// advanced on every clock and every DUT output is compared against it.
// Directed steps cover decode examples, backpressure, flush and mid-stream
// reset; random phases cover back-to-back throughput and mixed traffic.
// -----------------------------------------------------------------------------

module tb_alu_issue;

    import common::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    ALU_CTR      alu_ctrl;
    logic [4:0]  rd;
    logic        wen;
    logic        illegal;
    logic [63:0] out_pc;

    alu_issue dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .rd        (rd),
        .wen       (wen),
        .illegal   (illegal),
        .out_pc    (out_pc)
    );

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        ALU_CTR      ctrl;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
        logic [63:0] pc;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    logic m_valid;
    exp_t m_p;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode: what the spec says one instruction turns into.
    function automatic exp_t model(input logic [31:0] i, input logic [63:0] p,
                                   input logic [63:0] r1, input logic [63:0] r2);
        exp_t        e;
        logic        ok;
        ALU_CTR      op3;
        logic        op3_ok;
        logic [63:0] sx_i;
        logic [63:0] sx_u;
        sx_i = {{52{i[31]}}, i[31:20]};
        sx_u = {{32{i[31]}}, i[31:12], 12'h000};
        op3_ok = 1'b1;
        op3    = ADD;
        if      (i[14:12] == 3'd0) op3 = ADD;
        else if (i[14:12] == 3'd4) op3 = XOR;
        else if (i[14:12] == 3'd6) op3 = OR;
        else if (i[14:12] == 3'd7) op3 = AND;
        else                       op3_ok = 1'b0;
        e    = '0;
        e.ctrl = ADD;
        ok   = 1'b0;
        if (i[6:0] == 7'h33 && i[31:25] == 7'h00 && op3_ok) begin
            ok = 1'b1; e.ctrl = op3; e.a = r1; e.b = r2;
        end else if (i[6:0] == 7'h33 && i[31:25] == 7'h20 && i[14:12] == 3'd0) begin
            ok = 1'b1; e.ctrl = SUB; e.a = r1; e.b = r2;
        end else if (i[6:0] == 7'h13 && op3_ok) begin
            ok = 1'b1; e.ctrl = op3; e.a = r1; e.b = sx_i;
        end else if (i[6:0] == 7'h37) begin
            ok = 1'b1; e.a = 64'd0; e.b = sx_u;
        end else if (i[6:0] == 7'h17) begin
            ok = 1'b1; e.a = p; e.b = sx_u;
        end
        e.rd  = i[11:7];
        e.ill = !ok;
        e.wen = ok && (i[11:7] != 5'd0);
        e.pc  = p;
        return e;
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [2:0]  f3s [4];
        logic [31:0] w;
        logic [4:0]  r_d, r_1, r_2;
        int unsigned k;
        f3s[0] = 3'd0; f3s[1] = 3'd4; f3s[2] = 3'd6; f3s[3] = 3'd7;
        r_d = 5'($urandom_range(0, 31));
        r_1 = 5'($urandom_range(0, 31));
        r_2 = 5'($urandom_range(0, 31));
        k   = $urandom_range(0, 6);
        w   = $urandom;
        case (k)
            0, 1:    w = {7'h00, r_2, r_1, f3s[$urandom_range(0, 3)], r_d, 7'h33};
            2:       w = {7'h20, r_2, r_1, 3'd0, r_d, 7'h33};
            3, 4:    w = {w[31:20], r_1, f3s[$urandom_range(0, 3)], r_d, 7'h13};
            5:       w = {w[31:12], r_d, 7'h37};
            default: w = {w[31:12], r_d, 7'h17};
        endcase
        return w;
    endfunction

    task automatic offer(input logic v, input logic [31:0] i, input logic [63:0] p,
                         input logic [63:0] r1, input logic [63:0] r2);
        in_valid = v; instr = i; pc = p; rs1_data = r1; rs2_data = r2;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, ".alu_a"},     alu_a,          m_p.a);
        chk({tag, ".alu_b"},     alu_b,          m_p.b);
        chk({tag, ".alu_ctrl"},  64'(alu_ctrl),  64'(m_p.ctrl));
        chk({tag, ".rd"},        64'(rd),        64'(m_p.rd));
        chk({tag, ".wen"},       64'(wen),       64'(m_p.wen));
        chk({tag, ".illegal"},   64'(illegal),   64'(m_p.ill));
        chk({tag, ".out_pc"},    out_pc,         m_p.pc);
    endtask

    // One clock: check in_ready before the edge, advance the model at the
    // edge, then compare every output shortly after it.
    task automatic tick(input string tag);
        exp_t nxt;
        logic acc;
        #1;
        nxt = model(instr, pc, rs1_data, rs2_data);
        acc = in_valid && (!m_valid || out_ready) && !flush;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(!m_valid || out_ready));
        @(posedge clk);
        if (!reset) begin
            m_valid = 1'b0;
            m_p     = '0;
            m_p.ctrl = ADD;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_p     = nxt;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        offer(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
        m_valid = 1'b0; m_p = '0; m_p.ctrl = ADD;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset.in_ready", 64'(in_ready), 64'd1);

        reset = 1'b1; out_ready = 1'b1;

        // Decode examples
        offer(1'b1, 32'h002081B3, 64'h1000, 64'd5, 64'd7);
        tick("add");
        chk("add.a_const", alu_a, 64'd5);
        chk("add.b_const", alu_b, 64'd7);
        chk("add.ctrl_const", 64'(alu_ctrl), 64'(ADD));
        chk("add.rd_const", 64'(rd), 64'd3);
        chk("add.wen_const", 64'(wen), 64'd1);

        offer(1'b1, 32'h402081B3, 64'h1004, 64'd9, 64'd4);
        tick("sub");
        chk("sub.ctrl_const", 64'(alu_ctrl), 64'(SUB));

        offer(1'b1, 32'hFFF0C293, 64'h1008, 64'h1234, 64'h0);
        tick("xori");
        chk("xori.ctrl_const", 64'(alu_ctrl), 64'(XOR));
        chk("xori.b_const", alu_b, 64'hFFFF_FFFF_FFFF_FFFF);

        offer(1'b1, 32'h800000B7, 64'h100C, 64'h55, 64'h66);
        tick("lui");
        chk("lui.a_const", alu_a, 64'd0);
        chk("lui.b_const", alu_b, 64'hFFFF_FFFF_8000_0000);

        offer(1'b1, 32'h00001097, 64'h8000_0000, 64'h55, 64'h66);
        tick("auipc");
        chk("auipc.a_const", alu_a, 64'h8000_0000);
        chk("auipc.b_const", alu_b, 64'h1000);

        offer(1'b1, 32'h002091B3, 64'h1010, 64'h3, 64'h4);
        tick("sll");
        chk("sll.illegal_const", 64'(illegal), 64'd1);
        chk("sll.wen_const", 64'(wen), 64'd0);
        chk("sll.a_const", alu_a, 64'd0);

        offer(1'b1, 32'h00000013, 64'h1014, 64'h3, 64'h4);
        tick("addi_x0");
        chk("addi_x0.illegal_const", 64'(illegal), 64'd0);
        chk("addi_x0.wen_const", 64'(wen), 64'd0);

        // Backpressure: entry A held while three offers are refused
        offer(1'b1, 32'h00310233, 64'h2000, 64'd11, 64'd22);
        tick("bp_load");
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            offer(1'b1, rand_legal(), 64'h3000 + 64'(k * 4), 64'($urandom), 64'($urandom));
            tick("bp_hold");
            chk("bp_hold.in_ready_const", 64'(in_ready), 64'd0);
            chk("bp_hold.pc_const", out_pc, 64'h2000);
        end

        // Flush with a valid offer while the entry is held
        flush = 1'b1;
        offer(1'b1, 32'h002081B3, 64'h4000, 64'd1, 64'd2);
        tick("flush");
        chk("flush.valid_const", 64'(out_valid), 64'd0);
        chk("flush.pc_const", out_pc, 64'h2000);
        flush = 1'b0; out_ready = 1'b1;
        offer(1'b1, 32'h0020C1B3, 64'h4004, 64'd1, 64'd2);
        tick("post_flush");
        chk("post_flush.pc_const", out_pc, 64'h4004);

        // Reset mid-stream with a held entry
        out_ready = 1'b0;
        offer(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
        tick("pre_reset");
        reset = 1'b0;
        tick("mid_reset");
        chk("mid_reset.valid_const", 64'(out_valid), 64'd0);
        chk("mid_reset.pc_const", out_pc, 64'd0);
        reset = 1'b1;
        #1;
        chk("mid_reset.in_ready_const", 64'(in_ready), 64'd1);

        // Back-to-back throughput, 100 random legal instructions
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            offer(1'b1, rand_legal(), 64'h1_0000 + 64'(k * 4),
                  {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)});
            tick("stream");
            chk("stream.valid_const", 64'(out_valid), 64'd1);
            chk("stream.pc_seq", out_pc, 64'h1_0000 + 64'(k * 4));
        end

        // Mixed random traffic
        for (int k = 0; k < 300; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 9) == 0);
            reset     = !($urandom_range(0, 49) == 0);
            offer(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom) : rand_legal(),
                  {32'($urandom), 32'($urandom)},
                  {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)});
            tick("random");
        end

        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        offer(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
        repeat (2) tick("drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_issue
